// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive sweeper for a small combinational circuit.
// Drives every input vector, samples after a settle delay, scores against a table.
module truth_table_sweeper #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int SETTLE = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [N_OUT*(2**N_IN)-1:0]   exp_table,
   output logic [N_IN-1:0]              dut_in,
   input  logic [N_OUT-1:0]             dut_out,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [N_IN:0]                err_count,
   output logic                         fail_seen,
   output logic [N_IN-1:0]              first_fail_idx,
   output logic                         cap_valid,
   output logic [N_IN-1:0]              cap_idx,
   output logic [N_OUT-1:0]             cap_data,
   output logic                         cap_err
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST   = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE, S_SETTLE, S_CAPTURE, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [N_IN:0]     err_q, err_d;
   logic              fail_q, fail_d;
   logic [N_IN-1:0]   ffi_q, ffi_d;
   logic              cv_q, cv_d;
   logic [N_IN-1:0]   cidx_q, cidx_d;
   logic [N_OUT-1:0]  cdata_q, cdata_d;
   logic              cerr_q, cerr_d;
   logic [N_OUT-1:0]  exp_vec;
   logic              mism;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fail_q  <= 1'b0;
         ffi_q   <= '0;
         cv_q    <= 1'b0;
         cidx_q  <= '0;
         cdata_q <= '0;
         cerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         ffi_q   <= ffi_d;
         cv_q    <= cv_d;
         cidx_q  <= cidx_d;
         cdata_q <= cdata_d;
         cerr_q  <= cerr_d;
      end
   end

   always_comb begin
      exp_vec = exp_table[int'(idx_q)*N_OUT +: N_OUT];
      mism    = (dut_out != exp_vec);
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      fail_d  = fail_q;
      ffi_d   = ffi_q;
      cv_d    = 1'b0;
      cidx_d  = cidx_q;
      cdata_d = cdata_q;
      cerr_d  = cerr_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               cnt_d   = RELOAD;
               err_d   = '0;
               fail_d  = 1'b0;
               ffi_d   = '0;
               pass_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            busy_d = 1'b1;
            if (cnt_q == '0) state_d = S_CAPTURE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_CAPTURE: begin
            cv_d    = 1'b1;
            cidx_d  = idx_q;
            cdata_d = dut_out;
            cerr_d  = mism;
            if (mism) begin
               err_d = err_q + (N_IN+1)'(1);
               if (!fail_q) begin
                  fail_d = 1'b1;
                  ffi_d  = idx_q;
               end
            end
            // pass must reflect a mismatch on the final vector too
            if (idx_q == LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               busy_d  = 1'b1;
               idx_d   = idx_q + N_IN'(1);
               cnt_d   = RELOAD;
               state_d = S_SETTLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign dut_in         = idx_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign fail_seen      = fail_q;
   assign first_fail_idx = ffi_q;
   assign cap_valid      = cv_q;
   assign cap_idx        = cidx_q;
   assign cap_data       = cdata_q;
   assign cap_err        = cerr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: SETTLE=1 and SETTLE=3 instances
// sweeping D=(A&B)|C, E=~C, with optional E-stuck-at-0 fault.
module tb_truth_table_sweeper;

   localparam int NV = 8;

   typedef struct {
      int u; int idx; int data; int err; int at;
   } cap_t;
   typedef struct {
      int u; int at; int pass; int errc; int ffi;
   } sum_t;

   logic        clk;
   logic        rst [2];
   logic        start [2];
   logic [15:0] exp_table;
   logic [2:0]  din [2];
   logic [1:0]  dout [2];
   logic        busy [2];
   logic        done [2];
   logic        pass [2];
   logic [3:0]  errc [2];
   logic        fseen [2];
   logic [2:0]  ffi [2];
   logic        cv [2];
   logic [2:0]  cidx [2];
   logic [1:0]  cdata [2];
   logic        cerr [2];
   bit          fault [2];

   cap_t cq [$];
   sum_t dq [$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   bit   mon_en = 0;
   bit   sw_on [2];
   int   sw_at [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int st(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   function automatic logic [1:0] circ(input int v, input bit f);
      logic a, b, c;
      a = v[2];
      b = v[1];
      c = v[0];
      return {(a & b) | c, f ? 1'b0 : ~c};
   endfunction

   assign dout[0] = circ(int'(din[0]), fault[0]);
   assign dout[1] = circ(int'(din[1]), fault[1]);

   truth_table_sweeper u_dut0 (
      .clk(clk), .rst(rst[0]), .start(start[0]),
      .exp_table(exp_table), .dut_in(din[0]), .dut_out(dout[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .err_count(errc[0]), .fail_seen(fseen[0]),
      .first_fail_idx(ffi[0]), .cap_valid(cv[0]),
      .cap_idx(cidx[0]), .cap_data(cdata[0]), .cap_err(cerr[0])
   );

   truth_table_sweeper #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst[1]), .start(start[1]),
      .exp_table(exp_table), .dut_in(din[1]), .dut_out(dout[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .err_count(errc[1]), .fail_seen(fseen[1]),
      .first_fail_idx(ffi[1]), .cap_valid(cv[1]),
      .cap_idx(cidx[1]), .cap_data(cdata[1]), .cap_err(cerr[1])
   );

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act == expv) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    nm, act, expv, cyc);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int u = 0; u < 2; u++) begin
            int   rel, edin, ebusy, s;
            cap_t e;
            sum_t d;
            s = st(u);
            edin = 0;
            ebusy = 0;
            if (sw_on[u]) begin
               rel = cyc - sw_at[u];
               edin = rel / (s + 1);
               if (edin > NV - 1) edin = NV - 1;
               ebusy = (rel >= 1 && rel < NV * (s + 1)) ? 1 : 0;
               if (rel == 0) begin
                  chk("err_count cleared", int'(errc[u]), 0);
                  chk("fail_seen cleared", int'(fseen[u]), 0);
                  chk("pass cleared", int'(pass[u]), 0);
               end
            end
            chk($sformatf("busy u%0d", u), int'(busy[u]), ebusy);
            chk($sformatf("dut_in u%0d", u), int'(din[u]), edin);
            if (cv[u]) begin
               if (cq.size() == 0) chk("unexpected cap_valid", 1, 0);
               else begin
                  e = cq.pop_front();
                  chk("cap unit", u, e.u);
                  chk("cap time", cyc, e.at);
                  chk("cap_idx", int'(cidx[u]), e.idx);
                  chk("cap_data", int'(cdata[u]), e.data);
                  chk("cap_err", int'(cerr[u]), e.err);
               end
            end
            if (done[u]) begin
               if (dq.size() == 0) chk("unexpected done", 1, 0);
               else begin
                  d = dq.pop_front();
                  chk("done unit", u, d.u);
                  chk("done time", cyc, d.at);
                  chk("pass", int'(pass[u]), d.pass);
                  chk("err_count", int'(errc[u]), d.errc);
                  chk("fail_seen", int'(fseen[u]), (d.errc != 0) ? 1 : 0);
                  if (d.errc != 0)
                     chk("first_fail_idx", int'(ffi[u]), d.ffi);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input int u);
      @(negedge clk);
      chk("rst dut_in", int'(din[u]), 0);
      chk("rst busy", int'(busy[u]), 0);
      chk("rst done", int'(done[u]), 0);
      chk("rst pass", int'(pass[u]), 0);
      chk("rst err_count", int'(errc[u]), 0);
      chk("rst fail_seen", int'(fseen[u]), 0);
      chk("rst first_fail_idx", int'(ffi[u]), 0);
      chk("rst cap_valid", int'(cv[u]), 0);
      chk("rst cap_idx", int'(cidx[u]), 0);
      chk("rst cap_data", int'(cdata[u]), 0);
      chk("rst cap_err", int'(cerr[u]), 0);
   endtask

   task automatic do_reset(input int u, input bit with_start);
      rst[u] = 1'b1;
      start[u] = with_start;
      tick();
      rst[u] = 1'b0;
      start[u] = 1'b0;
      sw_on[u] = 1'b0;
      cq.delete();
      dq.delete();
      check_zero(u);
   endtask

   task automatic go(input int u, input bit f);
      int s, nerr, first;
      s = st(u);
      fault[u] = f;
      start[u] = 1'b1;
      tick();
      start[u] = 1'b0;
      sw_on[u] = 1'b1;
      sw_at[u] = cyc;
      nerr = 0;
      first = 0;
      for (int k = 0; k < NV; k++) begin
         int dv, er;
         dv = int'(circ(k, f));
         er = (dv != int'(circ(k, 1'b0))) ? 1 : 0;
         if (er != 0 && nerr == 0) first = k;
         nerr += er;
         cq.push_back('{u, k, dv, er, cyc + (k + 1) * (s + 1)});
      end
      dq.push_back('{u, cyc + NV * (s + 1), (nerr == 0) ? 1 : 0,
                     nerr, first});
   endtask

   task automatic pulse_ignored(input int u);
      start[u] = 1'b1;
      tick();
      start[u] = 1'b0;
   endtask

   task automatic wait_rel(input int u, input int target);
      int n;
      n = 0;
      while ((cyc - sw_at[u]) < target && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) chk("wait budget", 0, 1);
   endtask

   initial begin
      rst = '{1'b1, 1'b1};
      start = '{1'b0, 1'b0};
      fault = '{1'b0, 1'b0};
      sw_on = '{1'b0, 1'b0};
      sw_at = '{0, 0};
      for (int v = 0; v < NV; v++) exp_table[v*2 +: 2] = circ(v, 1'b0);
      repeat (3) tick();
      rst = '{1'b0, 1'b0};
      check_zero(0);
      check_zero(1);
      mon_en = 1'b1;

      go(0, 1'b1);
      wait_rel(0, 16);
      pulse_ignored(0);
      go(0, 1'b0);
      wait_rel(0, 11);
      pulse_ignored(0);
      wait_rel(0, 16);
      repeat (2) tick();

      go(0, 1'b1);
      wait_rel(0, 6);
      do_reset(0, 1'b1);
      repeat ($urandom_range(1, 4)) tick();
      go(0, 1'b0);
      wait_rel(0, 16);
      repeat (3) tick();

      go(1, ($urandom_range(0, 1) == 1));
      wait_rel(1, 32);
      repeat (3) tick();

      chk("captures outstanding", cq.size(), 0);
      chk("summaries outstanding", dq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
